lab1_vector_sequencer: RTL and testbench
========================================

# lab1_vector_sequencer

Self-checking stimulus sequencer for the Lab 1 four-input combinational function unit, F(A,B,C,D). On a start pulse it drives all 16 input combinations in ascending binary order, holds each for a programmable dwell time, samples F and compares it against a parameterised truth table. It then reports pass/fail, the number of mismatches, the first failing vector and the full captured response. It sits beside the function unit as an on-chip built-in self-test (BIST) controller that replaces the bench-driven exhaustive sweep.

## Interface
- DWELL, 4: clock cycles each vector is held; legal range 1..255.
- EXPECTED, 16'h0000: golden truth table; bit i is the expected F for vector i, where i = {A,B,C,D} and A is the MSB.

- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle request to begin a sweep.
- abort  in  1  synchronous cancel of a sweep in progress.
- f_in  in  1  F output of the function unit.
- a, b, c, d  out  1 each  registered stimulus to the function unit.
- busy  out  1  sweep in progress.
- done  out  1  results valid; held until the next start, abort or reset.
- pass  out  1  all 16 samples matched; valid only while done=1.
- fail_count  out  5  number of mismatches, 0..16.
- first_fail_idx  out  4  index of the lowest mismatching vector; 0 if none.
- sig  out  16  captured F values; bit i is the sample for vector i.

## Operation
- State machine states: IDLE, RUN, DONE.
- Internal registers: idx (4 bits), dwell_cnt (8 bits), fail_seen (1 bit).
- Reset: state is IDLE. a, b, c, d, busy, done, pass, fail_count, first_fail_idx, sig, idx, dwell_cnt and fail_seen are all 0.
- IDLE, or DONE, with start=1 and abort=0:
  - go to RUN;
  - idx=0, dwell_cnt=0;
  - clear sig, fail_count, first_fail_idx and fail_seen;
  - busy=1, done=0, pass=0.
- RUN drives {a,b,c,d}=idx. Each cycle:
  - If dwell_cnt != DWELL-1, increment dwell_cnt.
  - Otherwise:
    - capture sig[idx]=f_in;
    - if f_in != EXPECTED[idx], increment fail_count;
    - on a mismatch with fail_seen=0, set first_fail_idx=idx and fail_seen=1;
    - then if idx=15, go to DONE; otherwise increment idx and set dwell_cnt=0.
- On the RUN→DONE transition:
  - busy=0, done=1;
  - pass=1 exactly when the final fail_count is 0, counting the last vector's compare;
  - a, b, c, d return to 0.
- DONE holds all results until start or abort.
- abort=1 in any state, next cycle:
  - go to IDLE;
  - busy=0, done=0, pass=0;
  - a, b, c, d, sig, fail_count, first_fail_idx and fail_seen are cleared.
- Simultaneous start and abort: abort wins.
- start while in RUN is ignored.
- idx never wraps; the sweep ends after vector 15.
- fail_count saturates naturally at 16 because there are only 16 compares.

## Timing
- The start edge is cycle 0. busy rises and vector 0 appears at the output after that edge.
- Vector i is driven for cycles i·DWELL+1 through (i+1)·DWELL.
- f_in is sampled on the last of those cycles. This allows up to DWELL-1 cycles of settling through the function unit.
- done rises exactly 16·DWELL cycles after the start edge, and busy falls on the same edge.
- All outputs are registered, with no combinational path from inputs to outputs.
- Restart from DONE: start in the same cycle that done is seen launches a new sweep, and done falls on the next edge.
- Reset mid-sweep: all outputs are 0 immediately, without waiting for a clock edge.

## Test plan
- Golden match: EXPECTED=16'hA5C3, DWELL=4, f_in modelled as EXPECTED[{a,b,c,d}], one start pulse → {a,b,c,d} steps 0..15, each held 4 cycles; done=1 at cycle 64; pass=1, fail_count=0, sig=16'hA5C3, first_fail_idx=0.
- Single fault: same setup with f_in inverted only while idx=5 → pass=0, fail_count=1, first_fail_idx=5, sig=16'hA5E3.
- Stuck-at-0: f_in=0 throughout, EXPECTED=16'hA5C3 → fail_count=8, first_fail_idx=0, sig=16'h0000; then EXPECTED=16'hA5C0 gives first_fail_idx=6.
- DWELL=1 boundary: golden model → done at cycle 16; each vector is held exactly one cycle; pass=1.
- Abort and start conflicts:
  - abort while idx=7 → next cycle busy=0, done=0, {a,b,c,d}=0, sig=0;
  - start during RUN has no effect on idx or dwell_cnt;
  - start and abort together in IDLE → stays in IDLE.
- Reset mid-run: deassert rst_n asynchronously at idx=10 → all outputs 0 immediately; a new start after release runs a full, clean 16-vector sweep.

Source files
------------

// File: rtl/lab1_vector_sequencer.sv
// Built-in self-test sequencer for the Lab 1 four-input function unit F(A,B,C,D).
// Sweeps all 16 input vectors, samples F after a dwell period and grades it against a golden table.
module lab1_vector_sequencer #(
  parameter int unsigned  DWELL    = 4,
  parameter logic [15:0]  EXPECTED = 16'h0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        abort,
  input  logic        f_in,
  output logic        a,
  output logic        b,
  output logic        c,
  output logic        d,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [4:0]  fail_count,
  output logic [3:0]  first_fail_idx,
  output logic [15:0] sig
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  localparam logic [7:0] DWELL_LAST = 8'(DWELL - 1);

  state_t      state;
  logic [3:0]  idx;
  logic [7:0]  dwell_cnt;
  logic        fail_seen;
  logic        mismatch;
  logic [4:0]  fail_next;

  // Grading of the current vector; only consumed on the last dwell cycle.
  assign mismatch  = f_in ^ EXPECTED[idx];
  assign fail_next = fail_count + 5'(mismatch);

  // Pass is decided from fail_next so the final vector's compare is included.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      idx            <= 4'd0;
      dwell_cnt      <= 8'd0;
      fail_seen      <= 1'b0;
      {a, b, c, d}   <= 4'd0;
      busy           <= 1'b0;
      done           <= 1'b0;
      pass           <= 1'b0;
      fail_count     <= 5'd0;
      first_fail_idx <= 4'd0;
      sig            <= 16'h0000;
    end else if (abort) begin
      state          <= IDLE;
      idx            <= 4'd0;
      dwell_cnt      <= 8'd0;
      fail_seen      <= 1'b0;
      {a, b, c, d}   <= 4'd0;
      busy           <= 1'b0;
      done           <= 1'b0;
      pass           <= 1'b0;
      fail_count     <= 5'd0;
      first_fail_idx <= 4'd0;
      sig            <= 16'h0000;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state          <= RUN;
            idx            <= 4'd0;
            dwell_cnt      <= 8'd0;
            fail_seen      <= 1'b0;
            {a, b, c, d}   <= 4'd0;
            busy           <= 1'b1;
            done           <= 1'b0;
            pass           <= 1'b0;
            fail_count     <= 5'd0;
            first_fail_idx <= 4'd0;
            sig            <= 16'h0000;
          end
        end
        RUN: begin
          if (dwell_cnt != DWELL_LAST) begin
            dwell_cnt <= dwell_cnt + 8'd1;
          end else begin
            sig[idx]   <= f_in;
            fail_count <= fail_next;
            if (mismatch && !fail_seen) begin
              first_fail_idx <= idx;
              fail_seen      <= 1'b1;
            end
            // The sweep stops after vector 15 instead of letting idx wrap.
            if (idx == 4'd15) begin
              state        <= DONE;
              busy         <= 1'b0;
              done         <= 1'b1;
              pass         <= (fail_next == 5'd0);
              {a, b, c, d} <= 4'd0;
            end else begin
              idx          <= idx + 4'd1;
              dwell_cnt    <= 8'd0;
              {a, b, c, d} <= idx + 4'd1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lab1_vector_sequencer.sv
// Randomised bench for lab1_vector_sequencer: three instances (DWELL 4/1, two golden tables)
// graded every cycle against a sweep-level model of what each output must show.
module tb_lab1_vector_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [2:0]  start;
  logic [2:0]  abort;
  logic [2:0]  f_in;
  logic [2:0]  a, b, c, d, busy, done, pass;
  logic [4:0]  fail_count [3];
  logic [3:0]  first_fail_idx [3];
  logic [15:0] sig [3];

  int vectors = 0;
  int miscompares = 0;

  // Model state per instance: 0 idle, 1 sweeping, 2 results held.
  int          mst [3] = '{0, 0, 0};
  int          mt [3] = '{0, 0, 0};
  logic [15:0] resp_cur [3] = '{16'h0, 16'h0, 16'h0};
  logic [15:0] resp_pending [3] = '{16'h0, 16'h0, 16'h0};

  always #5 clk = ~clk;

  function automatic int dw_of(input int g);
    return (g == 1) ? 1 : 4;
  endfunction

  function automatic logic [15:0] ex_of(input int g);
    return (g == 2) ? 16'hA5C0 : 16'hA5C3;
  endfunction

  for (genvar g = 0; g < 3; g++) begin : g_dut
    lab1_vector_sequencer #(
      .DWELL    ((g == 1) ? 1 : 4),
      .EXPECTED ((g == 2) ? 16'hA5C0 : 16'hA5C3)
    ) u_dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .start          (start[g]),
      .abort          (abort[g]),
      .f_in           (f_in[g]),
      .a              (a[g]),
      .b              (b[g]),
      .c              (c[g]),
      .d              (d[g]),
      .busy           (busy[g]),
      .done           (done[g]),
      .pass           (pass[g]),
      .fail_count     (fail_count[g]),
      .first_fail_idx (first_fail_idx[g]),
      .sig            (sig[g])
    );
  end

  function automatic logic [3:0] vec_of(input int g);
    return {a[g], b[g], c[g], d[g]};
  endfunction

  function automatic logic [31:0] actual_of(input int g);
    return {busy[g], done[g], pass[g], vec_of(g), fail_count[g], first_fail_idx[g], sig[g]};
  endfunction

  // Expected outputs derived from how many vectors have been graded so far.
  function automatic logic [31:0] expected_of(input int g);
    int          n;
    logic [15:0] m, mis, sv;
    logic [4:0]  fc;
    logic [3:0]  first, vec;
    logic        bz, dn, ps;
    if (mst[g] == 0) return 32'h0;
    n   = (mst[g] == 1) ? mt[g] / dw_of(g) : 16;
    vec = (mst[g] == 1) ? 4'(mt[g] / dw_of(g)) : 4'd0;
    bz  = (mst[g] == 1);
    dn  = (mst[g] == 2);
    m   = 16'((32'd1 << n) - 1);
    sv  = resp_cur[g] & m;
    mis = (resp_cur[g] ^ ex_of(g)) & m;
    fc  = 5'($countones(mis));
    first = 4'd0;
    for (int i = 15; i >= 0; i--) if (mis[i]) first = 4'(i);
    ps  = dn && (fc == 5'd0);
    return {bz, dn, ps, vec, fc, first, sv};
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int g = 0; g < 3; g++) begin
        mst[g] <= 0;
        mt[g]  <= 0;
      end
    end else begin
      for (int g = 0; g < 3; g++) begin
        if (abort[g]) begin
          mst[g] <= 0;
        end else if (start[g] && mst[g] != 1) begin
          mst[g]      <= 1;
          mt[g]       <= 0;
          resp_cur[g] <= resp_pending[g];
        end else if (mst[g] == 1) begin
          mt[g] <= mt[g] + 1;
          if (mt[g] + 1 == 16 * dw_of(g)) mst[g] <= 2;
        end
      end
    end
  end

  // Per-cycle compare, then drive F: noise while settling, the true response on the sample cycle.
  always @(negedge clk) begin
    for (int g = 0; g < 3; g++) begin
      vectors++;
      if (actual_of(g) !== expected_of(g)) begin
        miscompares++;
        $display("[TB] FAIL outputs[%0d] @%0t: got 0x%08h, expected 0x%08h", g, $time, actual_of(g), expected_of(g));
      end
    end
    for (int g = 0; g < 3; g++) begin
      if (mst[g] == 1 && (mt[g] % dw_of(g)) == dw_of(g) - 1)
        f_in[g] = resp_cur[g][mt[g] / dw_of(g)];
      else
        f_in[g] = 1'($urandom_range(0, 1));
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input int g, input logic s, input logic ab);
    @(negedge clk);
    start[g] = s;
    abort[g] = ab;
    @(negedge clk);
    start[g] = 1'b0;
    abort[g] = 1'b0;
  endtask

  task automatic beginSweep(input int g, input logic [15:0] mask);
    resp_pending[g] = ex_of(g) ^ mask;
    applyStimulus(g, 1'b1, 1'b0);
  endtask

  task automatic waitVec(input int g, input logic [3:0] v);
    int k = 0;
    while (vec_of(g) != v && k < 100) begin
      @(negedge clk);
      k++;
    end
    checkOutput("wait_vec", {28'h0, vec_of(g)}, {28'h0, v});
  endtask

  // Full sweep; optionally re-pulses start at cycle 'poke' (ignored while running).
  task automatic runSweep(input int g, input logic [15:0] mask, input int poke, output int lat);
    resp_pending[g] = ex_of(g) ^ mask;
    @(negedge clk);
    start[g] = 1'b1;
    @(negedge clk);
    start[g] = 1'b0;
    lat = 0;
    while (!done[g] && lat < 16 * dw_of(g) + 8) begin
      @(negedge clk);
      lat++;
      start[g] = (lat == poke);
    end
    start[g] = 1'b0;
  endtask

  initial begin
    int          lat, g, poke;
    logic [15:0] mask;
    rst_n = 1'b0;
    start = 3'b000;
    abort = 3'b000;
    repeat (3) @(negedge clk);
    checkOutput("reset_state", actual_of(0), 32'h0);
    rst_n = 1'b1;

    runSweep(0, 16'h0000, -1, lat);
    checkOutput("golden_latency", lat, 64);
    checkOutput("golden_sig", sig[0], 16'hA5C3);
    checkOutput("golden_fc", fail_count[0], 0);
    checkOutput("golden_pass", pass[0], 1);
    checkOutput("golden_first", first_fail_idx[0], 0);

    runSweep(0, 16'h0020, 37, lat);
    checkOutput("fault5_pass", pass[0], 0);
    checkOutput("fault5_fc", fail_count[0], 1);
    checkOutput("fault5_first", first_fail_idx[0], 5);
    checkOutput("fault5_sig", sig[0], 16'hA5E3);
    checkOutput("poke_latency", lat, 64);

    runSweep(0, 16'hA5C3, -1, lat);
    checkOutput("stuck0_fc", fail_count[0], 8);
    checkOutput("stuck0_first", first_fail_idx[0], 0);
    checkOutput("stuck0_sig", sig[0], 16'h0000);
    runSweep(2, 16'hA5C0, -1, lat);
    checkOutput("stuck0_c0_first", first_fail_idx[2], 6);
    checkOutput("stuck0_c0_fc", fail_count[2], 6);

    runSweep(1, 16'h0000, -1, lat);
    checkOutput("dwell1_latency", lat, 16);
    checkOutput("dwell1_pass", pass[1], 1);

    beginSweep(0, 16'($urandom));
    waitVec(0, 4'd7);
    abort[0] = 1'b1;
    @(negedge clk);
    abort[0] = 1'b0;
    checkOutput("abort_busy", busy[0], 0);
    checkOutput("abort_done", done[0], 0);
    checkOutput("abort_vec", vec_of(0), 0);
    checkOutput("abort_sig", sig[0], 0);

    applyStimulus(0, 1'b1, 1'b1);
    checkOutput("start_abort_idle", {busy[0], done[0]}, 0);

    beginSweep(0, 16'h0000);
    waitVec(0, 4'd10);
    #2 rst_n = 1'b0;
    #1 checkOutput("async_reset", actual_of(0), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    runSweep(0, 16'h0000, -1, lat);
    checkOutput("post_reset_latency", lat, 64);
    checkOutput("post_reset_pass", pass[0], 1);

    for (int it = 0; it < 10; it++) begin
      g    = $urandom_range(0, 2);
      mask = ($urandom_range(0, 2) == 0) ? 16'h0000 : 16'($urandom);
      poke = $urandom_range(1, 16 * dw_of(g) - 1);
      runSweep(g, mask, poke, lat);
      checkOutput("rand_latency", lat, 16 * dw_of(g));
      checkOutput("rand_fc", fail_count[g], $countones(mask));
      checkOutput("rand_pass", pass[g], (mask == 16'h0000));
      checkOutput("rand_sig", sig[g], ex_of(g) ^ mask);
    end

    for (int it = 0; it < 3; it++) begin
      g = $urandom_range(0, 2);
      beginSweep(g, 16'($urandom));
      repeat ($urandom_range(0, 14)) @(negedge clk);
      abort[g] = 1'b1;
      @(negedge clk);
      abort[g] = 1'b0;
      checkOutput("rand_abort", actual_of(g), 32'h0);
    end

    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
